// File: rtl/ncl_seq_pkg.sv
// Shared definitions for the NCL zero-detector sequencer: state encoding,
// rail width, default phase timeout and the dual-rail detector codes.
package ncl_seq_pkg;

    // Rail width of the NCL zero detector this sequencer drives.
    localparam int NCL_W       = 8;
    // Clock cycles allowed per wavefront phase before the phase is abandoned.
    localparam int DEF_TIMEOUT = 15;

    // Sequencer states; plain constants so older tools see a simple vector.
    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_NULL = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    // Detector output codes, bit order {zero_t, zero_f}.
    localparam logic [1:0] DET_NULL    = 2'b00;
    localparam logic [1:0] DET_ZERO    = 2'b10;
    localparam logic [1:0] DET_NONZERO = 2'b01;
    localparam logic [1:0] DET_ILLEGAL = 2'b11;

    // What the FSM cares about: wavefront done, wavefront cleared, or broken.
    typedef enum logic [1:0] {
        DCLS_NULL    = 2'd0,
        DCLS_DATA    = 2'd1,
        DCLS_ILLEGAL = 2'd2
    } det_cls_e;

    // Response payload held stable for the consumer.
    typedef struct packed {
        logic zero;
        logic err;
    } rsp_t;

    // Collapse a sampled detector code into its wavefront class.
    function automatic det_cls_e det_classify(input logic [1:0] code);
        case (code)
            DET_NULL:              return DCLS_NULL;
            DET_ZERO, DET_NONZERO: return DCLS_DATA;
            default:               return DCLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/ncl_det_sync.sv
// Sampling stage for the detector's zero_t/zero_f rails.
// Build option NCL_ZERO_SYNC_EN: when defined, each rail passes through a
// two-flop synchronizer (the second flop is det_s); otherwise a single
// sample flop is used. These flops have no reset on purpose: they must keep
// sampling through reset so the INIT state sees whatever the detector is
// really holding (e.g. a stale DATA result kept by hysteresis).
module ncl_det_sync
    import ncl_seq_pkg::*;
(
    input  logic       clk,
    input  logic       i_det_t,
    input  logic       i_det_f,
    output logic [1:0] o_det_s
);

`ifdef NCL_ZERO_SYNC_EN
    logic [1:0] r_meta;
    logic [1:0] r_sync;

    // Two-flop synchronizer per rail; the detector settles asynchronously.
    always_ff @(posedge clk) begin
        r_meta <= {i_det_t, i_det_f};
        r_sync <= r_meta;
    end

    assign o_det_s = r_sync;
`else
    logic [1:0] r_samp;

    // Single sample register; detector assumed settled within one clock.
    always_ff @(posedge clk) begin
        r_samp <= {i_det_t, i_det_f};
    end

    assign o_det_s = r_samp;
`endif

endmodule

// File: rtl/ncl_zero_sequencer.sv
// Clocked controller that walks the 8-bit dual-rail NCL zero detector through
// a DATA wavefront and a NULL wavefront per operand, then reports zero/error
// on a valid/ready response channel.
// Build option NCL_ZERO_SYNC_EN (see ncl_det_sync) adds a synchronizer flop
// to the detector sampling path; results are identical, each wait is 1 cycle
// longer.
// WIDTH must stay 8 to match the detector; 2**CNT_W must exceed TIMEOUT.
module ncl_zero_sequencer
    import ncl_seq_pkg::*;
#(
    parameter int WIDTH   = NCL_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [WIDTH-1:0] ncl_t,
    output logic [WIDTH-1:0] ncl_f,
    input  logic             det_zero_t,
    input  logic             det_zero_f,
    output logic             busy
);

    logic [1:0]       w_det_s;
    det_cls_e         w_det_cls;
    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_timeout;
    logic             w_phase_timed;
    logic             w_load;
    rsp_t             r_rsp;
    rsp_t             w_rsp_nxt;
    logic [WIDTH-1:0] r_ncl_t;
    logic [WIDTH-1:0] r_ncl_f;

    ncl_det_sync u_det_sync (
        .clk     (clk),
        .i_det_t (det_zero_t),
        .i_det_f (det_zero_f),
        .o_det_s (w_det_s)
    );

    assign w_det_cls     = det_classify(w_det_s);
    assign w_timeout     = (r_cnt == CNT_W'(TIMEOUT));
    assign w_phase_timed = (r_state == S_INIT) || (r_state == S_DATA) ||
                           (r_state == S_NULL);

    // Next-state, response capture and operand-load decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_rsp_nxt   = r_rsp;
        w_load      = 1'b0;
        case (r_state)
            S_INIT: begin
                // Wait out any DATA the detector still holds after reset.
                if (w_det_cls == DCLS_NULL || w_timeout)
                    w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (req_valid) begin
                    w_load      = 1'b1;
                    w_rsp_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_det_cls == DCLS_DATA) begin
                    w_rsp_nxt.zero = w_det_s[1];
                    w_rsp_nxt.err  = 1'b0;
                    w_state_nxt    = S_NULL;
                end else if (w_det_cls == DCLS_ILLEGAL || w_timeout) begin
                    w_rsp_nxt.zero = 1'b0;
                    w_rsp_nxt.err  = 1'b1;
                    w_state_nxt    = S_NULL;
                end
            end
            S_NULL: begin
                if (w_det_cls == DCLS_NULL) begin
                    w_state_nxt = S_RESP;
                end else if (w_timeout) begin
                    w_rsp_nxt.err = 1'b1;
                    w_state_nxt   = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready)
                    w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    // State register; reset lands in INIT so the detector is re-qualified.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_INIT;
        else
            r_state <= w_state_nxt;
    end

    // Per-phase timeout counter: cleared on any state change, saturating.
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_state_nxt != r_state)
            r_cnt <= '0;
        else if (w_phase_timed && !w_timeout)
            r_cnt <= r_cnt + 1'b1;
    end

    // Rails carry the operand only while in DATA; any other next state is NULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ncl_t <= '0;
            r_ncl_f <= '0;
        end else if (w_load) begin
            r_ncl_t <= req_data;
            r_ncl_f <= ~req_data;
        end else if (w_state_nxt != S_DATA) begin
            r_ncl_t <= '0;
            r_ncl_f <= '0;
        end
    end

    // Response payload, held stable through RESP until the handshake.
    always_ff @(posedge clk) begin
        if (rst)
            r_rsp <= '0;
        else
            r_rsp <= w_rsp_nxt;
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign busy      = (r_state != S_IDLE);
    assign rsp_zero  = r_rsp.zero;
    assign rsp_err   = r_rsp.err;
    assign ncl_t     = r_ncl_t;
    assign ncl_f     = r_ncl_f;

endmodule

// File: tb/tb_ncl_zero_sequencer.sv
// Bench for ncl_zero_sequencer: behavioural detector, transaction scoreboard
// with per-cycle protocol checks, and directed tests with literal timing.
module tb_ncl_zero_sequencer;

`ifdef NCL_ZERO_SYNC_EN
    localparam int SW = 2;
`else
    localparam int SW = 1;
`endif
    localparam int LAT = 2 * (SW + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_zero;
    logic       rsp_err;
    logic [7:0] ncl_t;
    logic [7:0] ncl_f;
    logic       det_t = 1'b0;
    logic       det_f = 1'b0;
    logic       busy;

    // 0 = ideal detector with hysteresis, 1 = dead (stuck 0), 2 = manual
    int         det_mode = 0;
    logic       man_t = 1'b0;
    logic       man_f = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    ncl_zero_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .ncl_t      (ncl_t),
        .ncl_f      (ncl_f),
        .det_zero_t (det_t),
        .det_zero_f (det_f),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Zero-delay NCL zero detector: DATA once every rail pair is complete,
    // NULL once every rail is low, otherwise hold the previous output.
    always @(ncl_t, ncl_f, det_mode, man_t, man_f) begin : det_model
        logic nt, nf;
        nt = det_t;
        nf = det_f;
        case (det_mode)
            0: begin
                if ((ncl_t | ncl_f) == 8'hFF) begin
                    nt = (ncl_t == 8'h00);
                    nf = (ncl_t != 8'h00);
                end else if ((ncl_t | ncl_f) == 8'h00) begin
                    nt = 1'b0;
                    nf = 1'b0;
                end
            end
            1: begin
                nt = 1'b0;
                nf = 1'b0;
            end
            default: begin
                nt = man_t;
                nf = man_f;
            end
        endcase
        det_t = nt;
        det_f = nf;
    end

    typedef struct packed { logic zero; logic err; } exp_t;

    // Expected outcome of one transaction from the operand and the detector.
    function automatic exp_t model(input logic [7:0] op, input int mode);
        exp_t e;
        if (mode == 0) begin
            e.zero = (op == 8'h00);
            e.err  = 1'b0;
        end else begin
            // dead detector times out; manual mode is used for illegal codes
            e.zero = 1'b0;
            e.err  = 1'b1;
        end
        return e;
    endfunction

    exp_t       q[$];
    logic [7:0] cur_op = 8'h00;
    logic       p_hold = 1'b0;
    logic       p_zero = 1'b0;
    logic       p_err  = 1'b0;
    logic       p_rails_null = 1'b1;
    logic       p_det_null = 1'b1;

    // Per-cycle compare against the scoreboard and protocol rules.
    always @(negedge clk) begin : cmp
        logic       rails_null;
        logic [7:0] inv;
        if (rst) begin
            q.delete();
            p_hold       = 1'b0;
            p_rails_null = 1'b1;
            p_det_null   = !det_t && !det_f;
        end else begin
            rails_null = (ncl_t == 8'h00) && (ncl_f == 8'h00);
            inv        = ~cur_op;
            chk("busy_is_not_ready", busy, !req_ready);
            chk("ready_valid_overlap", req_ready && rsp_valid, 0);
            if (!rails_null) begin
                chk("rail_t_operand", ncl_t, cur_op);
                chk("rail_f_operand", ncl_f, inv);
                if (p_rails_null) chk("data_over_nonnull_det", p_det_null, 1);
            end
            if (rsp_valid) begin
                chk("rsp_rails_null", rails_null, 1);
                if (q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    chk("rsp_zero_model", rsp_zero, q[0].zero);
                    chk("rsp_err_model", rsp_err, q[0].err);
                end
            end
            if (p_hold) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_zero", rsp_zero, p_zero);
                chk("hold_err", rsp_err, p_err);
            end
            if (rsp_valid && rsp_ready && q.size() > 0) void'(q.pop_front());
            if (req_valid && req_ready) begin
                cur_op = req_data;
                q.push_back(model(req_data, det_mode));
            end
            p_hold       = rsp_valid && !rsp_ready;
            p_zero       = rsp_zero;
            p_err        = rsp_err;
            p_rails_null = rails_null;
            p_det_null   = !det_t && !det_f;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer an operand; returns just after the accepting edge.
    task automatic accept(input logic [7:0] op, input logic keep);
        int w;
        req_data  = op;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 200) begin
            tick();
            w++;
        end
        if (!req_ready) chk("accept_timeout", req_ready, 1);
        tick();
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int m;
        logic ok;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_data  = 8'h00;
        rsp_ready = 1'b1;
        tick(); tick(); tick();

        // reset state
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_ncl_t", ncl_t, 8'h00);
        chk("rst_ncl_f", ncl_f, 8'h00);
        chk("rst_busy", busy, 1);
        rst = 1'b0;
        tick();
        chk("init_to_idle", req_ready, 1);

        // 1: zero operand
        accept(8'h00, 1'b0);
        chk("t1_ncl_t", ncl_t, 8'h00);
        chk("t1_ncl_f", ncl_f, 8'hFF);
        wait_rsp(n);
        chk("t1_latency", n, LAT);
        chk("t1_zero", rsp_zero, 1);
        chk("t1_err", rsp_err, 0);
        chk("t1_rsp_ncl_t", ncl_t, 8'h00);
        chk("t1_rsp_ncl_f", ncl_f, 8'h00);
        tick();
        chk("t1_post_valid", rsp_valid, 0);
        chk("t1_post_ready", req_ready, 1);

        // 2: non-zero operands back to back
        accept(8'h80, 1'b1);
        chk("t2_ncl_t", ncl_t, 8'h80);
        chk("t2_ncl_f", ncl_f, 8'h7F);
        req_data = 8'h01;
        m = 0;
        ok = 1'b0;
        while (!ok && m < 100) begin
            if (rsp_valid) chk("t2_zero_a", rsp_zero, 0);
            ok = req_ready;
            tick();
            m++;
        end
        req_valid = 1'b0;
        chk("t2_second_accept", m, LAT + 2);
        chk("t2_ncl_t_b", ncl_t, 8'h01);
        chk("t2_ncl_f_b", ncl_f, 8'hFE);
        wait_rsp(n);
        chk("t2_latency_b", n, LAT);
        chk("t2_zero_b", rsp_zero, 0);
        chk("t2_err_b", rsp_err, 0);
        tick();

        // 3: response backpressure with a pending request
        rsp_ready = 1'b0;
        accept(8'h3C, 1'b0);
        req_data  = 8'h00;
        req_valid = 1'b1;
        wait_rsp(n);
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid", rsp_valid, 1);
            chk("t3_zero", rsp_zero, 0);
            chk("t3_err", rsp_err, 0);
            chk("t3_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("t3_hs_valid", rsp_valid, 0);
        chk("t3_hs_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("t3_accept_busy", busy, 1);
        chk("t3_accept_ncl_f", ncl_f, 8'hFF);
        wait_rsp(n);
        chk("t3_zero_b", rsp_zero, 1);
        tick();

        // 4: dead detector, DATA phase times out
        det_mode = 1;
        accept(8'h00, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        chk("t4_rails_held", ncl_f, 8'hFF);
        tick();
        chk("t4_rails_null", ncl_f, 8'h00);
        chk("t4_no_valid_yet", rsp_valid, 0);
        tick();
        chk("t4_valid", rsp_valid, 1);
        chk("t4_err", rsp_err, 1);
        chk("t4_zero", rsp_zero, 0);
        tick();
        det_mode = 0;

        // 5: illegal code during DATA, NULL waits for both rails to drop
        det_mode = 2;
        man_t = 1'b0;
        man_f = 1'b0;
        accept(8'h01, 1'b0);
        man_t = 1'b1;
        man_f = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5_no_valid", rsp_valid, 0);
        end
        chk("t5_ncl_t_null", ncl_t, 8'h00);
        chk("t5_ncl_f_null", ncl_f, 8'h00);
        man_t = 1'b0;
        man_f = 1'b0;
        for (int i = 0; i < SW; i++) tick();
        chk("t5_still_waiting", rsp_valid, 0);
        tick();
        chk("t5_valid", rsp_valid, 1);
        chk("t5_err", rsp_err, 1);
        chk("t5_zero", rsp_zero, 0);
        tick();

        // 6: reset mid-DATA while the detector holds zero_t by hysteresis
        accept(8'h00, 1'b0);
        man_t = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_ncl_t", ncl_t, 8'h00);
        chk("t6_rst_ncl_f", ncl_f, 8'h00);
        chk("t6_rst_ready", req_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_hold_ready", req_ready, 0);
            chk("t6_hold_valid", rsp_valid, 0);
        end
        man_t = 1'b0;
        for (int i = 0; i < SW; i++) tick();
        chk("t6_ready_low", req_ready, 0);
        tick();
        chk("t6_ready_high", req_ready, 1);
        chk("t6_no_valid", rsp_valid, 0);

        // recovery with the ideal detector
        det_mode = 0;
        accept(8'hFF, 1'b0);
        wait_rsp(n);
        chk("t7_latency", n, LAT);
        chk("t7_zero", rsp_zero, 0);
        chk("t7_err", rsp_err, 0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
